// File: rtl/hilo_divider_pkg.sv
// Shared definitions for the HI/LO divider: word width, reset level and FSM state encoding.
// Also holds the small magnitude helper used when capturing signed operands.
package hilo_divider_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W = 6;
  localparam logic RST_ACTIVE = 1'b1;
  localparam logic [CNT_W-1:0] LAST_ITER = 6'd31;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ON     = 2'd1,
    ST_BYZERO = 2'd2,
    ST_END    = 2'd3
  } state_t;

  // Absolute value for signed operands; unsigned operands pass straight through.
  function automatic logic [WORD_W-1:0] magnitude(input logic [WORD_W-1:0] v,
                                                  input logic is_signed);
    return (is_signed && v[WORD_W-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/hilo_divider.sv
// Multi-cycle radix-2 restoring divider producing quotient (LO) and remainder (HI).
// Signed division works on magnitudes with a sign fix-up applied when the result is latched.
module hilo_divider
  import hilo_divider_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              signed_i,
  input  logic [WORD_W-1:0] dividend_i,
  input  logic [WORD_W-1:0] divisor_i,
  input  logic              start_i,
  input  logic              annul_i,
  output logic              busy_o,
  output logic              hilo_we_o,
  output logic [WORD_W-1:0] hi_o,
  output logic [WORD_W-1:0] lo_o,
  output logic [1:0]        dbg_state
);

  // Handshake: a start is accepted in IDLE when start_i=1 and annul_i=0; busy_o
  // rises in that same cycle and stays high until END, where hilo_we_o pulses once.

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] dsr;
  logic [WORD_W-1:0] rem;
  logic [WORD_W-1:0] quo;
  logic              neg_q, neg_r;

  logic              accept;
  logic [WORD_W:0]   rem_shift;
  logic [WORD_W:0]   diff;
  logic              fits;
  logic [WORD_W-1:0] rem_nx, quo_nx;

  assign accept = (state == ST_IDLE) && start_i && !annul_i;

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (accept) state_n = (divisor_i == '0) ? ST_BYZERO : ST_ON;
      ST_ON: begin
        if (annul_i)                state_n = ST_IDLE;
        else if (cnt == LAST_ITER)  state_n = ST_END;
      end
      ST_BYZERO: state_n = annul_i ? ST_IDLE : ST_END;
      ST_END:    state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // One restoring step: shift the next dividend bit into the partial remainder
  // and subtract the divisor if it fits.
  always_comb begin
    rem_shift = {rem, quo[WORD_W-1]};
    diff      = rem_shift - {1'b0, dsr};
    fits      = !diff[WORD_W];
    rem_nx    = fits ? diff[WORD_W-1:0] : rem_shift[WORD_W-1:0];
    quo_nx    = {quo[WORD_W-2:0], fits};
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      state <= ST_IDLE;
      cnt   <= '0;
      dsr   <= '0;
      rem   <= '0;
      quo   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi_o  <= '0;
      lo_o  <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        dsr   <= magnitude(divisor_i, signed_i);
        quo   <= magnitude(dividend_i, signed_i);
        rem   <= '0;
        cnt   <= '0;
        neg_q <= signed_i && (dividend_i[WORD_W-1] ^ divisor_i[WORD_W-1]);
        neg_r <= signed_i && dividend_i[WORD_W-1];
      end else if (state == ST_ON && !annul_i) begin
        rem <= rem_nx;
        quo <= quo_nx;
        cnt <= cnt + 1'b1;
        if (cnt == LAST_ITER) begin
          lo_o <= neg_q ? (~quo_nx + 1'b1) : quo_nx;
          hi_o <= neg_r ? (~rem_nx + 1'b1) : rem_nx;
        end
      end else if (state == ST_BYZERO && !annul_i) begin
        hi_o <= '0;
        lo_o <= '0;
      end
    end
  end

  // An in-flight operation does not stall the pipeline while reset is held.
  assign busy_o    = (!(rst == RST_ACTIVE) && (state == ST_ON || state == ST_BYZERO)) || accept;
  assign hilo_we_o = (state == ST_END);
  assign dbg_state = state;

endmodule

// File: doc/hilo_divider.md
HILO_DIVIDER -- requirements
Module: hilo_divider

Interface
REQ-001 SHALL have clock clk: input, 1 bit, rising-edge clock.
REQ-002 SHALL have reset rst: input, 1 bit; reset rst, synchronous, active-high; clock clk.
REQ-003 SHALL have signed_i: input, 1 bit; 1 means DIV (two's complement), 0 means DIVU.
REQ-004 SHALL have dividend_i: input, 32 bits; dividend, sampled only on an accepted start.
REQ-005 SHALL have divisor_i: input, 32 bits; divisor, sampled only on an accepted start.
REQ-006 SHALL have start_i: input, 1 bit; request to begin a division.
REQ-007 SHALL have annul_i: input, 1 bit; abort request (flush or exception).
REQ-008 SHALL have busy_o: output, 1 bit; pipeline stall request.
REQ-009 SHALL have hilo_we_o: output, 1 bit; one-cycle HI/LO write-enable pulse.
REQ-010 SHALL have hi_o: output, 32 bits; remainder, written to HI.
REQ-011 SHALL have lo_o: output, 32 bits; quotient, written to LO.

Function
REQ-012 SHALL implement the states IDLE, ON, BYZERO and END in a registered state register.
REQ-013 IDLE: start_i=1 and annul_i=0 SHALL accept the operation, capture the operands and clear the 6-bit iteration counter.
- Next state SHALL be BYZERO if divisor_i==0, otherwise ON.
REQ-014 Start accepted in cycle N SHALL give 32 ON cycles (N+1..N+32), one quotient bit per cycle (radix-2, restoring).
- END SHALL occur in cycle N+33.
REQ-015 BYZERO SHALL last exactly one cycle (N+1) and SHALL be followed by END in cycle N+2.
- Result SHALL be hi=0, lo=0.
REQ-016 END SHALL last exactly one cycle, with hilo_we_o=1 and valid hi_o/lo_o.
- Next state SHALL be IDLE unconditionally.
- start_i in END SHALL be ignored.
REQ-017 start_i in ON or BYZERO SHALL be ignored; operands SHALL NOT be recaptured.
REQ-018 annul_i=1 in ON or BYZERO SHALL return the state to IDLE next cycle.
- No hilo_we_o pulse SHALL occur.
- hi_o/lo_o SHALL be unchanged.
REQ-019 annul_i=1 with start_i=1 in IDLE SHALL NOT start an operation.
REQ-020 busy_o SHALL be combinational and SHALL be 1 when state is ON or BYZERO.
- It SHALL also be 1 when state is IDLE with start_i=1 and annul_i=0.
- It SHALL be 0 otherwise, including in END.
REQ-021 Signed mode SHALL divide magnitudes.
- Quotient SHALL be negated when the operand signs differ.
- Remainder SHALL take the sign of the dividend.
REQ-022 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0 (wrap, no trap).
REQ-023 hi_o and lo_o SHALL be registers, updated only on entering END, and SHALL hold their value otherwise.
REQ-024 hilo_we_o SHALL equal (state==END).

Reset
REQ-025 rst=1 at a rising edge SHALL force state=IDLE, counter=0, hi_o=0, lo_o=0 and hilo_we_o=0.
- This SHALL take precedence over all other inputs, including mid-operation.
REQ-026 busy_o SHALL be 0 while rst=1 is applied and start_i=0.

Structure
REQ-027 State encodings, the reset-active level and the 32-bit word width SHALL live in the shared defines file.
REQ-028 No sub-module SHALL be required; the iteration step, sign fix-up and FSM SHALL be in one module.

Verification
REQ-029 Unsigned 100/7 started in cycle N SHALL produce hilo_we_o=1 only in cycle N+33, with lo=14 and hi=2.
REQ-030 Signed -7/2 (0xFFFFFFF9/2) SHALL produce lo=0xFFFFFFFD and hi=0xFFFFFFFF.
REQ-031 Divisor 0 SHALL produce busy_o for cycles N..N+1 and hilo_we_o in cycle N+2, with hi=lo=0.
REQ-032 Signed 0x80000000/0xFFFFFFFF SHALL produce lo=0x80000000 and hi=0.
REQ-033 annul_i at ON cycle 10 SHALL give no pulse, an IDLE state next cycle and hi/lo held; an immediate restart of 9/3 SHALL then give lo=3, hi=0.
REQ-034 rst mid-ON SHALL give IDLE, outputs 0 and no hilo_we_o pulse thereafter.
